// File: rtl/ball_sprite_engine_if.sv
// Raster-in / pixel-out bundle between vga_sync, the ball sprite engine and the pins.
// slave is the engine side; master is the raster source and pin sink.
interface ball_sprite_engine_if;
    logic [9:0] x;
    logic [9:0] y;
    logic       blank;
    logic       HS_in;
    logic       VS_in;
    logic       enable;
    logic       HSync;
    logic       VSync;
    logic [2:0] Red;
    logic [2:0] Green;
    logic [1:0] Blue;
    logic       bounce;
    logic [9:0] pos_x;
    logic [9:0] pos_y;

    modport slave (
        input  x, y, blank, HS_in, VS_in, enable,
        output HSync, VSync, Red, Green, Blue, bounce, pos_x, pos_y
    );

    modport master (
        output x, y, blank, HS_in, VS_in, enable,
        input  HSync, VSync, Red, Green, Blue, bounce, pos_x, pos_y
    );
endinterface

// File: rtl/ball_sprite_engine.sv
// Two-stage pixel pipeline drawing a 32x32 1-bpp bouncing ball sprite as RGB332,
// with syncs delayed to stay aligned and motion applied only in vertical blank.
module ball_sprite_engine #(
    parameter int             H_ACTIVE      = 640,
    parameter int             V_ACTIVE      = 480,
    parameter int             SIZE          = 32,
    parameter int             X0            = 50,
    parameter int             Y0            = 60,
    parameter int             STEP          = 2,
    parameter bit             USE_ROM_IMAGE = 1'b0,
    parameter logic [1023:0]  ROM_IMAGE     = '0
) (
    input  logic                  CLK,
    input  logic                  RST,
    ball_sprite_engine_if.slave   bus
);

    typedef enum logic {INC = 1'b0, DEC = 1'b1} dir_t;

    typedef struct packed {
        dir_t       dir;
        logic [9:0] pos;
    } axis_t;

    localparam logic [9:0] LIM_X  = 10'(H_ACTIVE - SIZE);
    localparam logic [9:0] LIM_Y  = 10'(V_ACTIVE - SIZE);
    localparam logic [9:0] STEP_V = 10'(STEP);
    localparam logic [9:0] SIZE_V = 10'(SIZE);
    localparam logic [9:0] V_TICK = 10'(V_ACTIVE);
    localparam axis_t      RST_X  = '{dir: INC, pos: 10'(X0)};
    localparam axis_t      RST_Y  = '{dir: INC, pos: 10'(Y0)};

    // Built-in disc image: byte (row*4 + col/8), MSB is the leftmost pixel.
    function automatic logic [1023:0] ball_bits();
        logic [1023:0] img;
        logic [9:0]    idx;
        int            dx;
        int            dy;
        img = '0;
        for (int r = 0; r < 32; r++) begin
            for (int c = 0; c < 32; c++) begin
                dx  = 2 * c - 31;
                dy  = 2 * r - 31;
                idx = 10'(r * 32 + (c / 8) * 8 + 7 - (c % 8));
                if (dx * dx + dy * dy <= 961) begin
                    img[idx] = 1'b1;
                end else begin
                    img[idx] = 1'b0;
                end
            end
        end
        return img;
    endfunction

    localparam logic [1023:0] ROM_BITS = USE_ROM_IMAGE ? ROM_IMAGE : ball_bits();

    // One frame of motion for one axis; clamps at the wall and reverses.
    function automatic axis_t step_axis(input axis_t cur, input logic [9:0] lim);
        axis_t nxt;
        nxt = cur;
        case (cur.dir)
            INC: begin
                if (({1'b0, cur.pos} + {1'b0, STEP_V}) >= {1'b0, lim}) begin
                    nxt.pos = lim;
                    nxt.dir = DEC;
                end else begin
                    nxt.pos = cur.pos + STEP_V;
                end
            end
            DEC: begin
                if (cur.pos <= STEP_V) begin
                    nxt.pos = 10'd0;
                    nxt.dir = INC;
                end else begin
                    nxt.pos = cur.pos - STEP_V;
                end
            end
            default: nxt = cur;
        endcase
        return nxt;
    endfunction

    axis_t      ax_x_r, ax_y_r, ax_x_nxt_s, ax_y_nxt_s;
    logic [9:0] y_prev_r;
    logic       tick_s, move_s, bounce_nxt_s;

    logic [9:0] xs_s, ys_s;
    logic [6:0] addr_s;
    logic       inside_s;

    logic [7:0] rom_q_r;
    logic [2:0] xb_r;
    logic       inside_r, blank_r, hs_r, vs_r;

    logic       pix_s;
    logic [2:0] red_s, green_s;
    logic [1:0] blue_s;

    // Offsets wrap modulo 1024, so pixels left of/above the sprite compare as large.
    assign xs_s     = bus.x - ax_x_r.pos;
    assign ys_s     = bus.y - ax_y_r.pos;
    assign inside_s = (xs_s < SIZE_V) && (ys_s < SIZE_V);
    assign addr_s   = {ys_s[4:0], xs_s[4:3]};

    assign tick_s   = (bus.y == V_TICK) && (y_prev_r != V_TICK);
    assign move_s   = tick_s && bus.enable;

    assign bus.pos_x = ax_x_r.pos;
    assign bus.pos_y = ax_y_r.pos;

    // Next position/direction for both axes and the bounce flag.
    always_comb begin
        ax_x_nxt_s   = ax_x_r;
        ax_y_nxt_s   = ax_y_r;
        bounce_nxt_s = 1'b0;
        if (move_s) begin
            ax_x_nxt_s   = step_axis(ax_x_r, LIM_X);
            ax_y_nxt_s   = step_axis(ax_y_r, LIM_Y);
            bounce_nxt_s = (ax_x_nxt_s.dir != ax_x_r.dir) || (ax_y_nxt_s.dir != ax_y_r.dir);
        end else begin
            ax_x_nxt_s   = ax_x_r;
            ax_y_nxt_s   = ax_y_r;
            bounce_nxt_s = 1'b0;
        end
    end

    // Motion state, frame-edge detector and bounce pulse.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            ax_x_r     <= RST_X;
            ax_y_r     <= RST_Y;
            y_prev_r   <= 10'd0;
            bus.bounce <= 1'b0;
        end else begin
            ax_x_r     <= ax_x_nxt_s;
            ax_y_r     <= ax_y_nxt_s;
            y_prev_r   <= bus.y;
            bus.bounce <= bounce_nxt_s;
        end
    end

    // Stage 1: ROM fetch plus the side-band that must travel with it.
    // Sync stages reset to the idle-high level so no sync glitch follows release.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            rom_q_r  <= 8'h00;
            xb_r     <= 3'd0;
            inside_r <= 1'b0;
            blank_r  <= 1'b0;
            hs_r     <= 1'b1;
            vs_r     <= 1'b1;
        end else begin
            rom_q_r  <= ROM_BITS[{addr_s, 3'b000} +: 8];
            xb_r     <= xs_s[2:0];
            inside_r <= inside_s;
            blank_r  <= bus.blank;
            hs_r     <= bus.HS_in;
            vs_r     <= bus.VS_in;
        end
    end

    assign pix_s = inside_r & rom_q_r[3'd7 - xb_r];

    // Colour choice: black in blanking, yellow ball, blue background.
    always_comb begin
        red_s   = 3'd0;
        green_s = 3'd0;
        blue_s  = 2'd0;
        if (blank_r) begin
            red_s   = 3'd0;
            green_s = 3'd0;
            blue_s  = 2'd0;
        end else if (pix_s) begin
            red_s   = 3'd7;
            green_s = 3'd7;
            blue_s  = 2'd0;
        end else begin
            red_s   = 3'd0;
            green_s = 3'd0;
            blue_s  = 2'd1;
        end
    end

    // Stage 2: registered pin outputs.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            bus.Red   <= 3'd0;
            bus.Green <= 3'd0;
            bus.Blue  <= 2'd0;
            bus.HSync <= 1'b1;
            bus.VSync <= 1'b1;
        end else begin
            bus.Red   <= red_s;
            bus.Green <= green_s;
            bus.Blue  <= blue_s;
            bus.HSync <= hs_r;
            bus.VSync <= vs_r;
        end
    end

endmodule

// File: tb/tb_ball_sprite_engine.sv
// Directed bench for ball_sprite_engine: pixel vector table plus hand-written
// reset, motion, bounce, corner and freeze sequences.
module tb_ball_sprite_engine;

    localparam logic [1023:0] IMG = (1024'h80) | (1024'h01 << 40) | (1024'h01 << 1016);

    logic clk;
    logic rst;
    int   total;
    int   bad;
    int   bcnt;
    int   cbcnt;
    int   b0;

    ball_sprite_engine_if bus ();
    ball_sprite_engine_if cbus ();

    ball_sprite_engine #(
        .USE_ROM_IMAGE (1'b1),
        .ROM_IMAGE     (IMG)
    ) u_dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    ball_sprite_engine #(
        .H_ACTIVE (41),
        .V_ACTIVE (41),
        .X0       (1),
        .Y0       (1)
    ) u_corner (
        .CLK (clk),
        .RST (rst),
        .bus (cbus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.bounce === 1'b1) bcnt++;
        if (cbus.bounce === 1'b1) cbcnt++;
    end

    typedef struct {
        logic [9:0] x;
        logic [9:0] y;
        logic       blank;
        logic       hs;
        logic       vs;
        logic [2:0] r;
        logic [2:0] g;
        logic [1:0] b;
    } vec_t;

    localparam int NV = 11;
    vec_t vt [NV];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick_main();
        bus.y = 10'd0;
        @(posedge clk); #1;
        bus.y = 10'd480;
        @(posedge clk); #1;
        bus.y = 10'd0;
    endtask

    task automatic tick_corner();
        cbus.y = 10'd0;
        @(posedge clk); #1;
        cbus.y = 10'd41;
        @(posedge clk); #1;
        cbus.y = 10'd0;
    endtask

    initial begin
        total = 0; bad = 0; bcnt = 0; cbcnt = 0;
        //            x      y      blk   hs    vs    R     G     B
        vt[0]  = '{10'd50, 10'd60, 1'b0, 1'b1, 1'b1, 3'd7, 3'd7, 2'd0};
        vt[1]  = '{10'd49, 10'd60, 1'b0, 1'b0, 1'b1, 3'd0, 3'd0, 2'd1};
        vt[2]  = '{10'd50, 10'd60, 1'b1, 1'b1, 1'b0, 3'd0, 3'd0, 2'd0};
        vt[3]  = '{10'd51, 10'd60, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 2'd1};
        vt[4]  = '{10'd65, 10'd61, 1'b0, 1'b1, 1'b1, 3'd7, 3'd7, 2'd0};
        vt[5]  = '{10'd64, 10'd61, 1'b0, 1'b1, 1'b0, 3'd0, 3'd0, 2'd1};
        vt[6]  = '{10'd81, 10'd91, 1'b0, 1'b0, 1'b1, 3'd7, 3'd7, 2'd0};
        vt[7]  = '{10'd82, 10'd91, 1'b0, 1'b1, 1'b1, 3'd0, 3'd0, 2'd1};
        vt[8]  = '{10'd81, 10'd92, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 2'd1};
        vt[9]  = '{10'd50, 10'd59, 1'b0, 1'b1, 1'b1, 3'd0, 3'd0, 2'd1};
        vt[10] = '{10'd65, 10'd61, 1'b1, 1'b0, 1'b1, 3'd0, 3'd0, 2'd0};

        rst = 1'b1;
        bus.x = 10'd0; bus.y = 10'd0; bus.blank = 1'b1;
        bus.HS_in = 1'b1; bus.VS_in = 1'b1; bus.enable = 1'b0;
        cbus.x = 10'd0; cbus.y = 10'd0; cbus.blank = 1'b1;
        cbus.HS_in = 1'b1; cbus.VS_in = 1'b1; cbus.enable = 1'b1;

        // T1: reset values
        repeat (3) @(posedge clk);
        #1;
        check("rst_red",   32'(bus.Red),   32'd0);
        check("rst_green", 32'(bus.Green), 32'd0);
        check("rst_blue",  32'(bus.Blue),  32'd0);
        check("rst_hsync", 32'(bus.HSync), 32'd1);
        check("rst_vsync", 32'(bus.VSync), 32'd1);
        check("rst_pos_x", 32'(bus.pos_x), 32'd50);
        check("rst_pos_y", 32'(bus.pos_y), 32'd60);
        check("rst_bounce", 32'(bus.bounce), 32'd0);
        rst = 1'b0;

        // T2: streamed pixel table, one new vector per clock, results 2 clocks later
        for (int i = 0; i < NV + 2; i++) begin
            @(posedge clk); #1;
            if (i >= 2) begin
                check($sformatf("vec%0d_red", i - 2),   32'(bus.Red),   32'(vt[i-2].r));
                check($sformatf("vec%0d_green", i - 2), 32'(bus.Green), 32'(vt[i-2].g));
                check($sformatf("vec%0d_blue", i - 2),  32'(bus.Blue),  32'(vt[i-2].b));
                check($sformatf("vec%0d_hsync", i - 2), 32'(bus.HSync), 32'(vt[i-2].hs));
                check($sformatf("vec%0d_vsync", i - 2), 32'(bus.VSync), 32'(vt[i-2].vs));
            end
            if (i < NV) begin
                bus.x = vt[i].x; bus.y = vt[i].y; bus.blank = vt[i].blank;
                bus.HS_in = vt[i].hs; bus.VS_in = vt[i].vs;
            end
        end
        bus.HS_in = 1'b1; bus.VS_in = 1'b1; bus.blank = 1'b1;

        // T3: one frame of motion
        bus.enable = 1'b1;
        b0 = bcnt;
        tick_main();
        check("move_pos_x", 32'(bus.pos_x), 32'd52);
        check("move_pos_y", 32'(bus.pos_y), 32'd62);
        check("move_bounce", 32'(bus.bounce), 32'd0);

        // T6: frozen across three frames, syncs still two clocks late
        bus.enable = 1'b0;
        repeat (3) tick_main();
        @(posedge clk); #1;
        check("freeze_pos_x", 32'(bus.pos_x), 32'd52);
        check("freeze_pos_y", 32'(bus.pos_y), 32'd62);
        check("freeze_bounces", 32'(bcnt - b0), 32'd0);
        bus.HS_in = 1'b0;
        @(posedge clk); #1;
        check("hs_delay1", 32'(bus.HSync), 32'd1);
        @(posedge clk); #1;
        check("hs_delay2", 32'(bus.HSync), 32'd0);
        bus.HS_in = 1'b1;

        // Mid-frame reset with a lit pixel on the inputs
        bus.x = 10'd52; bus.y = 10'd62; bus.blank = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("pre_rst_red", 32'(bus.Red), 32'd7);
        rst = 1'b1;
        #1;
        check("mid_rst_red",   32'(bus.Red),   32'd0);
        check("mid_rst_blue",  32'(bus.Blue),  32'd0);
        check("mid_rst_hsync", 32'(bus.HSync), 32'd1);
        check("mid_rst_pos_x", 32'(bus.pos_x), 32'd50);
        check("mid_rst_pos_y", 32'(bus.pos_y), 32'd60);
        bus.x = 10'd50; bus.y = 10'd60;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        check("post_rst_1clk_red", 32'(bus.Red), 32'd0);
        @(posedge clk); #1;
        check("post_rst_2clk_red", 32'(bus.Red), 32'd7);
        bus.blank = 1'b1;

        // T4: walk to pos_x=606 (Y bounces once at 448 on the way), then hit the right wall
        bus.enable = 1'b1;
        b0 = bcnt;
        repeat (278) tick_main();
        check("walk_pos_x", 32'(bus.pos_x), 32'd606);
        check("walk_pos_y", 32'(bus.pos_y), 32'd280);
        @(posedge clk); #1;
        check("walk_bounces", 32'(bcnt - b0), 32'd1);
        tick_main();
        check("xb_pos_x", 32'(bus.pos_x), 32'd608);
        check("xb_pos_y", 32'(bus.pos_y), 32'd278);
        check("xb_bounce_hi", 32'(bus.bounce), 32'd1);
        @(posedge clk); #1;
        check("xb_bounce_lo", 32'(bus.bounce), 32'd0);
        tick_main();
        check("xb_back_pos_x", 32'(bus.pos_x), 32'd606);
        check("xb_back_bounce", 32'(bus.bounce), 32'd0);

        // T5: corner instance, LIM=9 both axes, STEP=2 from (1,1)
        b0 = cbcnt;
        repeat (4) tick_corner();
        check("c_top_pos_x", 32'(cbus.pos_x), 32'd9);
        check("c_top_pos_y", 32'(cbus.pos_y), 32'd9);
        check("c_top_bounce", 32'(cbus.bounce), 32'd1);
        repeat (4) tick_corner();
        check("c_one_pos_x", 32'(cbus.pos_x), 32'd1);
        check("c_one_pos_y", 32'(cbus.pos_y), 32'd1);
        tick_corner();
        check("c_zero_pos_x", 32'(cbus.pos_x), 32'd0);
        check("c_zero_pos_y", 32'(cbus.pos_y), 32'd0);
        check("c_zero_bounce_hi", 32'(cbus.bounce), 32'd1);
        @(posedge clk); #1;
        check("c_zero_bounce_lo", 32'(cbus.bounce), 32'd0);
        check("c_pulse_count", 32'(cbcnt - b0), 32'd2);
        tick_corner();
        check("c_inc_pos_x", 32'(cbus.pos_x), 32'd2);
        check("c_inc_pos_y", 32'(cbus.pos_y), 32'd2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
